// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Default word width; the top module can override it.
   localparam int DEF_DATA_WIDTH = 16;

   // The bit counter has to hold DATA_WIDTH itself, not just DATA_WIDTH-1.
   function automatic int cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

   localparam int CNT_WIDTH = cnt_width(DEF_DATA_WIDTH);

   // A modifier of 0 selects a full word.
   function automatic int mod_to_count(input int mod, input int data_width);
      return (mod == 0) ? data_width : mod;
   endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, one bit per clock with a
// per-bit valid strobe. A word may be accepted during the last-bit cycle
// of the previous word, so consecutive words stream with no idle gap.
//
// state | meaning
// IDLE  | no word in flight, ser_data_val_o low, busy_o low
// SHIFT | emitting a word; cnt_q counts bits left including the one on the wire
module serializer
   import serializer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MOD_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [MOD_WIDTH-1:0]  data_mod_i,
   input  logic                  data_val_i,
   output logic                  ser_data_o,
   output logic                  ser_data_val_o,
   output logic                  busy_o
);

   localparam int CW = cnt_width(DATA_WIDTH);

   ser_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ser_data_q, ser_data_d;
   logic                  ser_val_q, ser_val_d;

   logic                  last_bit;
   logic                  busy;
   logic                  accept;
   logic [CW-1:0]         load_cnt;

   // Busy comes only from flops, so data_val_i has no combinational path to it.
   always_comb begin
      last_bit = (cnt_q == CW'(1));
      busy     = (state_q == SHIFT) && !last_bit;
      accept   = data_val_i && !busy;
      load_cnt = CW'(mod_to_count(int'(data_mod_i), DATA_WIDTH));
   end

   // Next-state, shift and output-bit selection.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      ser_data_d = 1'b0;
      ser_val_d  = 1'b0;

      if (accept) begin
         // The MSB goes straight to the output flop; the rest waits in the shifter.
         state_d    = SHIFT;
         shift_d    = {data_i[DATA_WIDTH-2:0], 1'b0};
         cnt_d      = load_cnt;
         ser_data_d = data_i[DATA_WIDTH-1];
         ser_val_d  = 1'b1;
      end else begin
         case (state_q)
            SHIFT: begin
               if (last_bit) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  ser_data_d = shift_q[DATA_WIDTH-1];
                  ser_val_d  = 1'b1;
                  shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
                  cnt_d      = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset abandons any word in flight at once.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         ser_data_q <= 1'b0;
         ser_val_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         ser_data_q <= ser_data_d;
         ser_val_q  <= ser_val_d;
      end
   end

   assign ser_data_o     = ser_data_q;
   assign ser_data_val_o = ser_val_q;
   assign busy_o         = busy;

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
Parallel-to-serial converter that sits directly upstream of the team's deserializer. It accepts a parallel word plus a bit-count modifier and emits the word MSB-first, one bit per clock, with a per-bit valid strobe. Its serial output pairs directly with the deserializer's serial input. A busy flag gives back-pressure to the word source, and the block supports back-to-back words with no idle gap.

Parameters:
DATA_WIDTH, 16, parallel word width in bits; must be at least 4.
MOD_WIDTH, $clog2(DATA_WIDTH), width of the bit-count modifier.

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
arst_n_i  input  1  reset; asynchronous, active-low.
data_i  input  DATA_WIDTH  parallel word; bit DATA_WIDTH-1 is sent first.
data_mod_i  input  MOD_WIDTH  number of bits to send, counted from the MSB; 0 means DATA_WIDTH.
data_val_i  input  1  word valid; accepted only when busy_o is 0.
ser_data_o  output  1  serial bit.
ser_data_val_o  output  1  ser_data_o is valid this cycle.
busy_o  output  1  high while a new word cannot be accepted.

Behaviour:
- Reset (arst_n_i=0, asynchronous assert): state=IDLE, shift register=0, bit counter=0, ser_data_o=0, ser_data_val_o=0, busy_o=0. Reset release is synchronous to clk_i.
- Reset mid-word: the word is abandoned immediately and no further bits are emitted. After release the block is in IDLE.
- Accept condition: rising edge with data_val_i=1 and busy_o=0.
  - On accept, latch data_i into the shift register.
  - Load the remaining count: DATA_WIDTH when data_mod_i=0, otherwise data_mod_i.
  - Go to SHIFT.
- Latency: the first bit (data_i[DATA_WIDTH-1]) appears on ser_data_o with ser_data_val_o=1 in the cycle after the accept edge.
- Bit output:
  - ser_data_val_o=1 for exactly N consecutive cycles, where N is the loaded count. No gaps are allowed inside a word.
  - Bits go out MSB-first. The shift register shifts left by one per cycle.
  - ser_data_o and ser_data_val_o are registered outputs.
  - ser_data_o=0 whenever ser_data_val_o=0.
- States:
  - IDLE: ser_data_val_o=0. On accept, go to SHIFT.
  - SHIFT: emit one bit per cycle and decrement the count.
  - On the last bit (count==1): go to IDLE, or reload and stay in SHIFT if a word is accepted on that edge.
- busy_o:
  - busy_o = (state==SHIFT) and not (count==1).
  - It is low in IDLE and in the last-bit cycle of a word. This allows back-to-back words with continuous ser_data_val_o.
  - busy_o is derived only from registered state, so there is no combinational path from data_val_i.
- data_val_i while busy_o=1: ignored. The word is dropped, state is unaffected, and no error is flagged.
- data_i and data_mod_i are sampled only on the accept edge; changes at other times have no effect.
- Counter width is $clog2(DATA_WIDTH+1), so it can hold DATA_WIDTH.
- Only data_mod_i=0 words produce complete words for the downstream deserializer; partial words are for other consumers.

Decomposition:
- Package serializer_pkg holds:
  - the state typedef (enum IDLE, SHIFT);
  - the localparam CNT_WIDTH = $clog2(DATA_WIDTH+1), as a function of DATA_WIDTH;
  - a function mapping data_mod_i to a bit count (0 -> DATA_WIDTH).
- Single module; no sub-module is needed.
- The testbench instantiates serializer with its output connected to the deserializer (DATA_WIDTH equal) for loopback checks.

Test Plan:
- Full word: data_i=16'hA5C3, mod=0, one pulse -> 16 valid cycles starting one cycle after accept, bits 1010_0101_1100_0011. busy_o is high for 15 cycles, then low.
- Partial word: data_i=16'hE000, mod=3 -> exactly 3 valid cycles, bits 1,1,1. busy_o is high for 2 cycles. ser_data_val_o=0 afterwards.
- Back-to-back: 16'hFFFF then 16'h0000, the second presented in the last-bit cycle of the first -> 32 continuous valid cycles (16 ones, then 16 zeros) with no gap.
- Drop while busy: pulse 16'h1234 while sending 16'hA5C3 -> output is exactly A5C3's 16 bits only, and no extra bits follow.
- Async reset at bit 7 of 16'hA5C3, asserted between clock edges -> ser_data_val_o and busy_o go to 0 immediately. After release no bits appear until the next accept.
- Loopback into the deserializer: random full words sent back-to-back -> each deserialized word equals the sent word. The deserializer's output valid fires once per word, one cycle after the 16th bit.
